// File: rtl/curve_lut_ram_if.sv
// Configuration bus for curve_lut_ram.
//   cfg_we     : shadow-table write strobe (accepted only while cfg_ready=1)
//   cfg_addr   : shadow-table write address (input code)
//   cfg_wdata  : shadow-table write data (output code)
//   cfg_commit : one-cycle request to swap the shadow table in at next frame start
//   cfg_ready  : high when writes and commit are accepted
// master = configuring agent, slave = curve_lut_ram.
interface curve_lut_ram_if #(
  parameter int DATA_W = 8
);
  logic              cfg_we;
  logic [DATA_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_commit;
  logic              cfg_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/curve_lut_ram.sv
// Double-buffered luminance curve lookup table.
// One bank maps the pixel stream while the other (shadow) bank takes cfg
// writes. A commit swaps the banks at the next vsync rising edge.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cfg                 : configuration bus (curve_lut_ram_if.slave)
//   per_frame_vsync/href/clken, per_img_Y   : input video
//   post_frame_vsync/href/clken, post_img_Y : mapped video, 2-cycle latency
//
// state   | meaning
// INIT    | fill both banks with identity, pixel path bypassed
// IDLE    | cfg writes/commit accepted
// PENDING | commit seen, waiting for vsync rise to swap banks
module curve_lut_ram #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  curve_lut_ram_if.slave    cfg,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Y,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y
);

  localparam int DEPTH = 1 << DATA_W;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] init_cnt;
  logic              bank_sel;
  logic              vsync_prev;
  logic              vsync_rise;

  logic              in_init;
  logic              cfg_ready_int;
  logic              swap_now;
  logic              active_sel;
  logic              wr0_en;
  logic              wr1_en;
  logic [DATA_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic [DATA_W-1:0] s1_rd0;
  logic [DATA_W-1:0] s1_rd1;
  logic              s1_sel;
  logic [2:0]        s1_sync;

  assign vsync_rise = per_frame_vsync & ~vsync_prev;

  // State register and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      bank_sel   <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      vsync_prev <= per_frame_vsync;
      if (in_init)  init_cnt <= init_cnt + 1'b1;
      if (swap_now) bank_sel <= ~bank_sel;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    if (&init_cnt)      state_nxt = ST_IDLE;
      ST_IDLE:    if (cfg.cfg_commit) state_nxt = ST_PENDING;
      ST_PENDING: if (vsync_rise)     state_nxt = ST_IDLE;
      default:                        state_nxt = ST_INIT;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_init       = (state == ST_INIT);
    cfg_ready_int = (state == ST_IDLE);
    swap_now      = (state == ST_PENDING) && vsync_rise;
    // The pixel sampled on the swap edge already uses the new bank.
    active_sel    = bank_sel ^ swap_now;
    wr_addr       = in_init ? init_cnt : cfg.cfg_addr;
    wr_data       = in_init ? init_cnt : cfg.cfg_wdata;
    wr0_en        = in_init | (cfg_ready_int & cfg.cfg_we & bank_sel);
    wr1_en        = in_init | (cfg_ready_int & cfg.cfg_we & ~bank_sel);
  end

  assign cfg.cfg_ready = cfg_ready_int;

  always_ff @(posedge clk) begin
    if (wr0_en) bank0[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr1_en) bank1[wr_addr] <= wr_data;
  end

  // Stage 1: both banks are read and the select is snapshotted with the
  // pixel, so a later swap cannot change which bank that pixel used.
  // During INIT the banks are incomplete, so the raw code bypasses them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rd0  <= '0;
      s1_rd1  <= '0;
      s1_sel  <= 1'b0;
      s1_sync <= '0;
    end else begin
      s1_rd0  <= in_init ? per_img_Y : bank0[per_img_Y];
      s1_rd1  <= in_init ? per_img_Y : bank1[per_img_Y];
      s1_sel  <= active_sel;
      s1_sync <= {per_frame_vsync, per_frame_href, per_frame_clken};
    end
  end

  // Stage 2: outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      post_img_Y       <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      post_img_Y       <= s1_sel ? s1_rd1 : s1_rd0;
      post_frame_vsync <= s1_sync[2];
      post_frame_href  <= s1_sync[1];
      post_frame_clken <= s1_sync[0];
    end
  end

endmodule

// File: tb/tb_curve_lut_ram.sv
module tb_curve_lut_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs, hr, ce;
  logic [7:0] y;
  logic       pvs, phr, pce;
  logic [7:0] py;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  curve_lut_ram_if #(.DATA_W(8)) cfg ();

  curve_lut_ram #(.DATA_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg              (cfg),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .per_img_Y        (y),
    .post_frame_vsync (pvs),
    .post_frame_href  (phr),
    .post_frame_clken (pce),
    .post_img_Y       (py)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    y = 8'hC3; vs = 1'b1; hr = 1'b1; ce = 1'b1;
    cfg.cfg_we = 1'b0; cfg.cfg_addr = '0; cfg.cfg_wdata = '0; cfg.cfg_commit = 1'b0;
    repeat (3) tick();
    checks++;
    if (py !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", py); end
    checks++;
    if ({pvs, phr, pce} !== 3'b000) begin errors++; $display("FAIL reset_sync: got %b expected 000", {pvs, phr, pce}); end
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cfg.cfg_ready); end
    y = 8'h00; vs = 1'b0; hr = 1'b0; ce = 1'b0;
  endtask

  // Release reset, check cfg_ready and the identity bypass/sync delay in INIT.
  task automatic test_init();
    logic [2:0] cur_s, prev_s;
    logic [7:0] cur_y, prev_y;
    prev_s = '0; prev_y = '0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL init_ready cycle %0d: got %b expected 0", i, cfg.cfg_ready); end
      cur_s = 3'($urandom_range(0, 7));
      cur_y = i[7:0] ^ 8'h5A;
      {vs, hr, ce} = cur_s;
      y = cur_y;
      tick();
      if (i >= 1) begin
        checks++;
        if (py !== prev_y) begin errors++; $display("FAIL init_bypass cycle %0d: got %h expected %h", i, py, prev_y); end
        checks++;
        if ({pvs, phr, pce} !== prev_s) begin errors++; $display("FAIL init_sync cycle %0d: got %b expected %b", i, {pvs, phr, pce}, prev_s); end
      end
      prev_s = cur_s;
      prev_y = cur_y;
    end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready: got %b expected 1", cfg.cfg_ready); end
    {vs, hr, ce} = 3'b000;
    tick();
  endtask

  task automatic test_identity();
    ce = 1'b0;
    y = 8'h40; tick();
    y = 8'h41; tick();
    checks++;
    if (py !== 8'h40) begin errors++; $display("FAIL identity_40: got %h expected 40", py); end
    tick();
    checks++;
    if (py !== 8'h41) begin errors++; $display("FAIL identity_41: got %h expected 41", py); end
  endtask

  task automatic test_commit_swap();
    for (int a = 0; a < 255; a++) begin
      cfg.cfg_we = 1'b1; cfg.cfg_addr = a[7:0]; cfg.cfg_wdata = ~a[7:0];
      tick();
    end
    cfg.cfg_we = 1'b0;
    y = 8'h10; tick(); tick();
    checks++;
    if (py !== 8'h10) begin errors++; $display("FAIL shadow_invisible: got %h expected 10", py); end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_before_commit: got %b expected 1", cfg.cfg_ready); end
    // last write shares the commit cycle
    cfg.cfg_we = 1'b1; cfg.cfg_addr = 8'hFF; cfg.cfg_wdata = 8'h00; cfg.cfg_commit = 1'b1;
    tick();
    cfg.cfg_we = 1'b0; cfg.cfg_commit = 1'b0;
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL pending_ready: got %b expected 0", cfg.cfg_ready); end
    y = 8'h20; tick();
    y = 8'h10; vs = 1'b1; tick();
    checks++;
    if (py !== 8'h20) begin errors++; $display("FAIL pre_swap_pixel: got %h expected 20", py); end
    y = 8'hFF; tick();
    checks++;
    if (py !== 8'hEF) begin errors++; $display("FAIL swap_edge_pixel: got %h expected ef", py); end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_swap: got %b expected 1", cfg.cfg_ready); end
    tick();
    checks++;
    if (py !== 8'h00) begin errors++; $display("FAIL commit_cycle_write: got %h expected 00", py); end
    vs = 1'b0; tick();
  endtask

  // Active bank1 = inverse, shadow bank0 = identity.
  task automatic test_pending_ignore();
    cfg.cfg_we = 1'b1; cfg.cfg_addr = 8'h10; cfg.cfg_wdata = 8'h33; tick();
    cfg.cfg_we = 1'b0; cfg.cfg_commit = 1'b1; tick();
    cfg.cfg_commit = 1'b0;
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL pending2_ready: got %b expected 0", cfg.cfg_ready); end
    cfg.cfg_we = 1'b1; cfg.cfg_addr = 8'h10; cfg.cfg_wdata = 8'h55; cfg.cfg_commit = 1'b1; tick();
    cfg.cfg_we = 1'b0; cfg.cfg_commit = 1'b0;
    y = 8'h10; tick(); tick();
    checks++;
    if (py !== 8'hEF) begin errors++; $display("FAIL pending_old_bank: got %h expected ef", py); end
    vs = 1'b1; y = 8'h10; tick();
    y = 8'h11; tick();
    checks++;
    if (py !== 8'h33) begin errors++; $display("FAIL pending_write_ignored: got %h expected 33", py); end
    tick();
    checks++;
    if (py !== 8'h11) begin errors++; $display("FAIL swap_back_identity: got %h expected 11", py); end
    vs = 1'b0; tick();
  endtask

  // Active bank0 = identity, shadow bank1 = inverse.
  task automatic test_commit_on_vsync();
    cfg.cfg_commit = 1'b1; vs = 1'b1; y = 8'h20; tick();
    cfg.cfg_commit = 1'b0; tick();
    checks++;
    if (py !== 8'h20) begin errors++; $display("FAIL commit_edge_no_swap: got %h expected 20", py); end
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_edge_pending: got %b expected 0", cfg.cfg_ready); end
    vs = 1'b0; tick();
    checks++;
    if (py !== 8'h20) begin errors++; $display("FAIL vsync_high_no_swap: got %h expected 20", py); end
    vs = 1'b1; y = 8'h20; tick();
    y = 8'h21; tick();
    checks++;
    if (py !== 8'hDF) begin errors++; $display("FAIL next_rise_swap: got %h expected df", py); end
    tick();
    checks++;
    if (py !== 8'hDE) begin errors++; $display("FAIL next_rise_swap2: got %h expected de", py); end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL next_rise_ready: got %b expected 1", cfg.cfg_ready); end
    vs = 1'b0; tick();
  endtask

  // Active bank1 = inverse, shadow bank0 = identity-ish.
  task automatic test_reset_pending();
    cfg.cfg_we = 1'b1; cfg.cfg_addr = 8'hA0; cfg.cfg_wdata = 8'h12; tick();
    cfg.cfg_we = 1'b0; cfg.cfg_commit = 1'b1; tick();
    cfg.cfg_commit = 1'b0;
    rst = 1'b1; y = 8'hA0;
    repeat (3) tick();
    checks++;
    if (py !== 8'h00) begin errors++; $display("FAIL reset2_y: got %h expected 00", py); end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL reinit_ready cycle %0d: got %b expected 0", i, cfg.cfg_ready); end
      tick();
    end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL reinit_done_ready: got %b expected 1", cfg.cfg_ready); end
    tick(); tick();
    checks++;
    if (py !== 8'hA0) begin errors++; $display("FAIL reinit_identity: got %h expected a0", py); end
    cfg.cfg_we = 1'b1; cfg.cfg_addr = 8'hA0; cfg.cfg_wdata = 8'h77; tick();
    cfg.cfg_we = 1'b0;
    vs = 1'b1; tick(); tick();
    checks++;
    if (py !== 8'hA0) begin errors++; $display("FAIL no_swap_after_reset: got %h expected a0", py); end
    vs = 1'b0;
    cfg.cfg_commit = 1'b1; tick();
    cfg.cfg_commit = 1'b0; tick();
    vs = 1'b1; tick(); tick();
    checks++;
    if (py !== 8'h77) begin errors++; $display("FAIL bank0_active_after_reset: got %h expected 77", py); end
    vs = 1'b0; tick();
  endtask

  task automatic test_sync_delay();
    logic [2:0] cur_s, prev_s;
    prev_s = {vs, hr, ce};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        cfg.cfg_commit = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
        cur_s = 3'($urandom_range(0, 7));
        {vs, hr, ce} = cur_s;
        tick();
        cfg.cfg_commit = 1'b0;
        checks++;
        if ({pvs, phr, pce} !== prev_s) begin errors++; $display("FAIL sync_delay pass %0d cycle %0d: got %b expected %b", pass, i, {pvs, phr, pce}, prev_s); end
        prev_s = cur_s;
      end
    end
    {vs, hr, ce} = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_identity();
    test_commit_swap();
    test_pending_ignore();
    test_commit_on_vsync();
    test_reset_pending();
    test_sync_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
